fleet_board: RTL and testbench

// Parametrised, multi-player successor of the fixed 10x10 ship matrix.

---
 rtl/board_pkg.sv | 39 +++
 rtl/board_cell_array.sv | 55 +++++
 rtl/fleet_board.sv | 247 ++++++++++++++++++++++++
 tb/tb_fleet_board.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared cell, opcode and response encodings for the fleet board, plus default sizing.
package board_pkg;

    localparam int DEF_PLAYERS = 2;
    localparam int DEF_BOARD_W = 10;
    localparam int DEF_BOARD_H = 10;
    localparam int DEF_MAX_LEN = 4;
    localparam int DEF_CNT_W   = 7;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'd0,
        CELL_SHIP  = 2'd1,
        CELL_HIT   = 2'd2,
        CELL_MISS  = 2'd3
    } cell_t;

    typedef enum logic [1:0] {
        OP_PLACE = 2'd0,
        OP_FIRE  = 2'd1,
        OP_CLEAR = 2'd2,
        OP_RSVD  = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        ST_OK          = 3'd0,
        ST_ERR_BOUNDS  = 3'd1,
        ST_ERR_OVERLAP = 3'd2,
        ST_HIT         = 3'd3,
        ST_MISS        = 3'd4,
        ST_REPEAT      = 3'd5,
        ST_ERR_OP      = 3'd6
    } status_t;

    // A single-entry dimension still needs a one-bit index.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/board_cell_array.sv
// Per-player cell storage: one write port, a combinational port for the FSM and a
// registered read-before-write port for the renderer.
module board_cell_array
    import board_pkg::*;
#(
    parameter int PLAYERS = DEF_PLAYERS,
    parameter int BOARD_W = DEF_BOARD_W,
    parameter int BOARD_H = DEF_BOARD_H,
    parameter int PW      = 1,
    parameter int XW      = 4,
    parameter int YW      = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [PW-1:0] wr_player,
    input  logic [XW-1:0] wr_x,
    input  logic [YW-1:0] wr_y,
    input  cell_t         wr_data,
    input  logic [PW-1:0] fsm_player,
    input  logic [XW-1:0] fsm_x,
    input  logic [YW-1:0] fsm_y,
    output cell_t         fsm_cell,
    input  logic [PW-1:0] rd_player,
    input  logic [XW-1:0] rd_x,
    input  logic [YW-1:0] rd_y,
    output cell_t         rd_cell
);

    cell_t mem [PLAYERS][BOARD_H][BOARD_W];

    logic rd_in_range;
    logic fsm_in_range;

    assign rd_in_range  = (int'(rd_player) < PLAYERS) && (int'(rd_x) < BOARD_W) && (int'(rd_y) < BOARD_H);
    assign fsm_in_range = (int'(fsm_player) < PLAYERS) && (int'(fsm_x) < BOARD_W) && (int'(fsm_y) < BOARD_H);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < PLAYERS; p++)
                for (int y = 0; y < BOARD_H; y++)
                    for (int x = 0; x < BOARD_W; x++)
                        mem[p][y][x] <= CELL_EMPTY;
            rd_cell <= CELL_EMPTY;
        end else begin
            if (we)
                mem[wr_player][wr_y][wr_x] <= wr_data;
            // Sampling the pre-edge array gives the renderer the old value on a same-cell write.
            rd_cell <= rd_in_range ? mem[rd_player][rd_y][rd_x] : CELL_EMPTY;
        end
    end

    assign fsm_cell = fsm_in_range ? mem[fsm_player][fsm_y][fsm_x] : CELL_EMPTY;

endmodule

// File: rtl/fleet_board.sv
// Multi-player battleship board: serialises PLACE/FIRE/CLEAR commands one cell per cycle
// and keeps per-player remaining-ship-cell counters for the game controller.
module fleet_board
    import board_pkg::*;
#(
    parameter  int PLAYERS = DEF_PLAYERS,
    parameter  int BOARD_W = DEF_BOARD_W,
    parameter  int BOARD_H = DEF_BOARD_H,
    parameter  int MAX_LEN = DEF_MAX_LEN,
    parameter  int CNT_W   = DEF_CNT_W,
    localparam int PW      = clog2_min1(PLAYERS),
    localparam int XW      = clog2_min1(BOARD_W),
    localparam int YW      = clog2_min1(BOARD_H),
    localparam int LW      = clog2_min1(MAX_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [PW-1:0]            cmd_player,
    input  logic [XW-1:0]            cmd_x,
    input  logic [YW-1:0]            cmd_y,
    input  logic [LW-1:0]            cmd_len,
    input  logic                     cmd_vert,
    output logic                     rsp_valid,
    output logic [2:0]               rsp_status,
    input  logic [PW-1:0]            rd_player,
    input  logic [XW-1:0]            rd_x,
    input  logic [YW-1:0]            rd_y,
    output logic [1:0]               rd_cell,
    output logic [PLAYERS*CNT_W-1:0] cells_left,
    output logic [PLAYERS-1:0]       all_sunk
);

    localparam int CELLS = BOARD_W * BOARD_H;
    localparam int SW    = clog2_min1(CELLS);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_WRITE, S_FIRE_RD, S_CLEAR_RUN, S_RESP
    } state_t;

    state_t           state;
    logic [PW-1:0]    lat_p;
    logic [LW-1:0]    lat_len;
    logic             lat_vert;
    logic [XW-1:0]    org_x, cur_x;
    logic [YW-1:0]    org_y, cur_y;
    logic [SW-1:0]    step;
    status_t          pend_status;
    logic [CNT_W-1:0] left_q [PLAYERS];
    logic [PLAYERS-1:0] armed;

    logic             we;
    cell_t            wr_data;
    cell_t            fsm_cell;
    cell_t            rd_cell_t;
    logic             bounds_err;
    logic             last_step;
    logic [CNT_W:0]   sum_place;

    board_cell_array #(
        .PLAYERS (PLAYERS),
        .BOARD_W (BOARD_W),
        .BOARD_H (BOARD_H),
        .PW      (PW),
        .XW      (XW),
        .YW      (YW)
    ) u_cells (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .wr_player  (lat_p),
        .wr_x       (cur_x),
        .wr_y       (cur_y),
        .wr_data    (wr_data),
        .fsm_player (lat_p),
        .fsm_x      (cur_x),
        .fsm_y      (cur_y),
        .fsm_cell   (fsm_cell),
        .rd_player  (rd_player),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_cell    (rd_cell_t)
    );

    assign rd_cell   = rd_cell_t;
    assign cmd_ready = (state == S_IDLE);

    // Ship-length checks only matter for PLACE; the coordinate checks guard every op.
    always_comb begin
        bounds_err = (int'(cmd_x) >= BOARD_W) || (int'(cmd_y) >= BOARD_H) ||
                     (int'(cmd_player) >= PLAYERS);
        if (op_t'(cmd_op) == OP_PLACE) begin
            if (cmd_len == '0 || int'(cmd_len) > MAX_LEN)
                bounds_err = 1'b1;
            else if (cmd_vert && (int'(cmd_y) + int'(cmd_len) > BOARD_H))
                bounds_err = 1'b1;
            else if (!cmd_vert && (int'(cmd_x) + int'(cmd_len) > BOARD_W))
                bounds_err = 1'b1;
        end
    end

    assign last_step = (state == S_CLEAR_RUN) ? (int'(step) == CELLS - 1)
                                              : (int'(step) == int'(lat_len) - 1);
    assign sum_place = {1'b0, left_q[lat_p]} + (CNT_W+1)'(lat_len);

    always_comb begin
        we      = 1'b0;
        wr_data = CELL_EMPTY;
        case (state)
            S_WRITE: begin
                we      = 1'b1;
                wr_data = CELL_SHIP;
            end
            S_FIRE_RD: begin
                we      = (fsm_cell == CELL_EMPTY) || (fsm_cell == CELL_SHIP);
                wr_data = (fsm_cell == CELL_EMPTY) ? CELL_MISS : CELL_HIT;
            end
            S_CLEAR_RUN: we = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        cells_left = '0;
        all_sunk   = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            cells_left[p*CNT_W +: CNT_W] = left_q[p];
            all_sunk[p] = (left_q[p] == '0) && armed[p];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            lat_p       <= '0;
            lat_len     <= '0;
            lat_vert    <= 1'b0;
            org_x       <= '0;
            org_y       <= '0;
            cur_x       <= '0;
            cur_y       <= '0;
            step        <= '0;
            pend_status <= ST_OK;
            rsp_valid   <= 1'b0;
            rsp_status  <= ST_OK;
            armed       <= '0;
            for (int p = 0; p < PLAYERS; p++)
                left_q[p] <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: if (cmd_valid) begin
                    lat_p    <= cmd_player;
                    lat_len  <= cmd_len;
                    lat_vert <= cmd_vert;
                    org_x    <= cmd_x;
                    org_y    <= cmd_y;
                    cur_x    <= cmd_x;
                    cur_y    <= cmd_y;
                    step     <= '0;
                    if (op_t'(cmd_op) == OP_RSVD) begin
                        pend_status <= ST_ERR_OP;
                        state       <= S_RESP;
                    end else if (bounds_err) begin
                        pend_status <= ST_ERR_BOUNDS;
                        state       <= S_RESP;
                    end else begin
                        case (op_t'(cmd_op))
                            OP_PLACE: state <= S_CHECK;
                            OP_FIRE:  state <= S_FIRE_RD;
                            default: begin
                                cur_x <= '0;
                                cur_y <= '0;
                                state <= S_CLEAR_RUN;
                            end
                        endcase
                    end
                end
                S_CHECK: begin
                    if (fsm_cell != CELL_EMPTY) begin
                        pend_status <= ST_ERR_OVERLAP;
                        state       <= S_RESP;
                    end else if (last_step) begin
                        cur_x <= org_x;
                        cur_y <= org_y;
                        step  <= '0;
                        state <= S_WRITE;
                    end else begin
                        if (lat_vert) cur_y <= cur_y + YW'(1);
                        else          cur_x <= cur_x + XW'(1);
                        step <= step + SW'(1);
                    end
                end
                S_WRITE: begin
                    if (last_step) begin
                        left_q[lat_p] <= sum_place[CNT_W] ? CNT_MAX : sum_place[CNT_W-1:0];
                        armed[lat_p]  <= 1'b1;
                        pend_status   <= ST_OK;
                        state         <= S_RESP;
                    end else begin
                        if (lat_vert) cur_y <= cur_y + YW'(1);
                        else          cur_x <= cur_x + XW'(1);
                        step <= step + SW'(1);
                    end
                end
                S_FIRE_RD: begin
                    case (fsm_cell)
                        CELL_EMPTY: pend_status <= ST_MISS;
                        CELL_SHIP: begin
                            pend_status <= ST_HIT;
                            if (left_q[lat_p] != '0)
                                left_q[lat_p] <= left_q[lat_p] - CNT_W'(1);
                        end
                        default: pend_status <= ST_REPEAT;
                    endcase
                    state <= S_RESP;
                end
                S_CLEAR_RUN: begin
                    if (last_step) begin
                        left_q[lat_p] <= '0;
                        armed[lat_p]  <= 1'b0;
                        pend_status   <= ST_OK;
                        state         <= S_RESP;
                    end else begin
                        if (int'(cur_x) == BOARD_W - 1) begin
                            cur_x <= '0;
                            cur_y <= cur_y + YW'(1);
                        end else begin
                            cur_x <= cur_x + XW'(1);
                        end
                        step <= step + SW'(1);
                    end
                end
                S_RESP: begin
                    rsp_valid  <= 1'b1;
                    rsp_status <= pend_status;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fleet_board.sv
// Directed and randomized bench for fleet_board against a plain-array game model.
module tb_fleet_board;

    localparam int P  = 2;
    localparam int W  = 10;
    localparam int H  = 10;
    localparam int ML = 4;
    localparam int CW = 7;

    localparam int ST_OK = 0, ST_BOUNDS = 1, ST_OVERLAP = 2, ST_HIT = 3;
    localparam int ST_MISS = 4, ST_REPEAT = 5, ST_ERROP = 6;
    localparam int C_EMPTY = 0, C_SHIP = 1, C_HIT = 2, C_MISS = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [1:0]      cmd_op;
    logic [0:0]      cmd_player;
    logic [3:0]      cmd_x;
    logic [3:0]      cmd_y;
    logic [2:0]      cmd_len;
    logic            cmd_vert;
    logic            rsp_valid;
    logic [2:0]      rsp_status;
    logic [0:0]      rd_player;
    logic [3:0]      rd_x;
    logic [3:0]      rd_y;
    logic [1:0]      rd_cell;
    logic [P*CW-1:0] cells_left;
    logic [P-1:0]    all_sunk;

    int checks = 0;
    int errors = 0;
    int board [P][H][W];
    int left  [P];
    bit armed [P];
    int firstRd;

    fleet_board dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_player (cmd_player),
        .cmd_x      (cmd_x),
        .cmd_y      (cmd_y),
        .cmd_len    (cmd_len),
        .cmd_vert   (cmd_vert),
        .rsp_valid  (rsp_valid),
        .rsp_status (rsp_status),
        .rd_player  (rd_player),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_cell    (rd_cell),
        .cells_left (cells_left),
        .all_sunk   (all_sunk)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    function automatic void modelReset();
        for (int p = 0; p < P; p++) begin
            left[p]  = 0;
            armed[p] = 1'b0;
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++)
                    board[p][y][x] = C_EMPTY;
        end
    endfunction

    // Game rules applied in one step; latency is the accept-to-response cycle count.
    function automatic void modelCmd(input int op, input int p, input int x, input int y,
                                     input int len, input bit vert, output int st, output int lat);
        int hitAt;
        st  = ST_OK;
        lat = 1;
        if (op == 3) begin
            st = ST_ERROP;
        end else if (x >= W || y >= H || p >= P) begin
            st = ST_BOUNDS;
        end else if (op == 0) begin
            if (len < 1 || len > ML || (vert ? (y + len > H) : (x + len > W))) begin
                st = ST_BOUNDS;
            end else begin
                hitAt = -1;
                for (int i = len - 1; i >= 0; i--)
                    if (board[p][vert ? y + i : y][vert ? x : x + i] != C_EMPTY) hitAt = i;
                if (hitAt >= 0) begin
                    st  = ST_OVERLAP;
                    lat = hitAt + 2;
                end else begin
                    for (int i = 0; i < len; i++)
                        board[p][vert ? y + i : y][vert ? x : x + i] = C_SHIP;
                    left[p]  = (left[p] + len > 127) ? 127 : left[p] + len;
                    armed[p] = 1'b1;
                    lat      = 2 * len + 1;
                end
            end
        end else if (op == 1) begin
            lat = 2;
            if (board[p][y][x] == C_EMPTY) begin
                board[p][y][x] = C_MISS;
                st = ST_MISS;
            end else if (board[p][y][x] == C_SHIP) begin
                board[p][y][x] = C_HIT;
                if (left[p] > 0) left[p]--;
                st = ST_HIT;
            end else begin
                st = ST_REPEAT;
            end
        end else begin
            for (int yy = 0; yy < H; yy++)
                for (int xx = 0; xx < W; xx++)
                    board[p][yy][xx] = C_EMPTY;
            left[p]  = 0;
            armed[p] = 1'b0;
            // W*H clearing cycles followed by the response cycle.
            lat      = W * H + 1;
        end
    endfunction

    task automatic applyStimulus(input int op, input int p, input int x, input int y,
                                 input int len, input bit vert, output int lat, output int st);
        @(negedge clk);
        checkOutput("ready_before_cmd", cmd_ready, 1);
        cmd_valid  = 1'b1;
        cmd_op     = op[1:0];
        cmd_player = p[0:0];
        cmd_x      = x[3:0];
        cmd_y      = y[3:0];
        cmd_len    = len[2:0];
        cmd_vert   = vert;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        lat = -1;
        st  = -1;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) firstRd = int'(rd_cell);
            if (rsp_valid === 1'b1) begin
                lat = n;
                st  = int'(rsp_status);
                break;
            end
        end
    endtask

    task automatic checkCounters(input string tag);
        for (int p = 0; p < P; p++) begin
            checkOutput($sformatf("%s_left_p%0d", tag, p), cells_left[p*CW +: CW], left[p]);
            checkOutput($sformatf("%s_sunk_p%0d", tag, p), all_sunk[p],
                        (left[p] == 0 && armed[p]) ? 1 : 0);
        end
    endtask

    task automatic runCmd(input string tag, input int op, input int p, input int x,
                          input int y, input int len, input bit vert);
        int expSt, expLat, lat, st;
        modelCmd(op, p, x, y, len, vert, expSt, expLat);
        applyStimulus(op, p, x, y, len, vert, lat, st);
        checkOutput({tag, "_status"}, st, expSt);
        checkOutput({tag, "_latency"}, lat, expLat);
        checkCounters(tag);
    endtask

    task automatic checkBoard(input string tag);
        for (int p = 0; p < P; p++)
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) begin
                    @(negedge clk);
                    rd_player = p[0:0];
                    rd_x      = x[3:0];
                    rd_y      = y[3:0];
                    @(posedge clk);
                    #1;
                    checkOutput($sformatf("%s_cell_p%0d_x%0d_y%0d", tag, p, x, y), rd_cell, board[p][y][x]);
                end
        @(negedge clk);
        rd_x = 4'd12;
        rd_y = 4'd0;
        @(posedge clk);
        #1;
        checkOutput({tag, "_rd_out_of_range"}, rd_cell, C_EMPTY);
    endtask

    task automatic setRead(input int p, input int x, input int y);
        @(negedge clk);
        rd_player = p[0:0];
        rd_x      = x[3:0];
        rd_y      = y[3:0];
    endtask

    initial begin
        int seen;
        int r, op;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_op     = 2'd0;
        cmd_player = 1'b0;
        cmd_x      = 4'd0;
        cmd_y      = 4'd0;
        cmd_len    = 3'd0;
        cmd_vert   = 1'b0;
        rd_player  = 1'b0;
        rd_x       = 4'd2;
        rd_y       = 4'd3;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_ready", cmd_ready, 1);
        checkOutput("reset_rsp_valid", rsp_valid, 0);
        checkOutput("reset_rsp_status", rsp_status, ST_OK);
        checkOutput("reset_cells_left", cells_left, 0);
        checkOutput("reset_all_sunk", all_sunk, 0);
        checkOutput("reset_rd_cell", rd_cell, C_EMPTY);
        @(negedge clk);
        rst = 1'b0;

        runCmd("place_h3", 0, 0, 2, 3, 3, 1'b0);
        runCmd("place_overlap", 0, 0, 3, 1, 4, 1'b1);
        runCmd("place_edge", 0, 1, 8, 0, 3, 1'b0);
        runCmd("place_len0", 0, 1, 0, 0, 0, 1'b0);
        runCmd("place_len5", 0, 1, 0, 0, 5, 1'b0);
        runCmd("fire_x_oob", 1, 1, 11, 0, 0, 1'b0);
        runCmd("reserved_op", 3, 0, 0, 0, 0, 1'b0);
        runCmd("place_p1_v2", 0, 1, 0, 5, 2, 1'b1);
        checkBoard("after_place");

        runCmd("fire_hit", 1, 0, 2, 3, 0, 1'b0);
        runCmd("fire_repeat", 1, 0, 2, 3, 0, 1'b0);
        setRead(0, 0, 0);
        runCmd("fire_miss", 1, 0, 0, 0, 0, 1'b0);
        checkOutput("miss_rd_cell", rd_cell, C_MISS);
        runCmd("fire_sink1", 1, 0, 3, 3, 0, 1'b0);
        runCmd("fire_sink2", 1, 0, 4, 3, 0, 1'b0);
        checkOutput("all_sunk_vec", all_sunk, 2'b01);
        @(posedge clk);
        #1;
        checkOutput("rsp_single_pulse", rsp_valid, 0);

        runCmd("clear_p0", 2, 0, 0, 0, 0, 1'b0);
        checkBoard("after_clear");

        runCmd("place_single", 0, 0, 1, 1, 1, 1'b0);
        setRead(0, 1, 1);
        runCmd("fire_rbw", 1, 0, 1, 1, 0, 1'b0);
        checkOutput("rbw_old_value", firstRd, C_SHIP);
        checkOutput("rbw_new_value", rd_cell, C_HIT);

        // Reset lands in the WRITE phase of a length-4 placement (writes occupy cycles 5..8).
        @(negedge clk);
        cmd_valid  = 1'b1;
        cmd_op     = 2'd0;
        cmd_player = 1'b1;
        cmd_x      = 4'd5;
        cmd_y      = 4'd5;
        cmd_len    = 3'd4;
        cmd_vert   = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_mid_ready", cmd_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        seen = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            #1;
            if (rsp_valid === 1'b1) seen++;
        end
        checkOutput("rst_mid_no_rsp", seen, 0);
        checkCounters("rst_mid");
        checkBoard("after_rst_mid");

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 19);
            op = (r < 9) ? 0 : (r < 16) ? 1 : (r == 16) ? 2 : 3;
            runCmd($sformatf("rand%0d", i), op, $urandom_range(0, 1), $urandom_range(0, 11),
                   $urandom_range(0, 11), $urandom_range(0, 5), 1'($urandom_range(0, 1)));
        end
        checkBoard("after_random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
